// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: the pipeline MEM stage owns the single memory port by
// default; an external loader/debug port takes it for fixed-length word bursts.
module dmem_arbiter #(
  parameter int MAX_PIPE_RUN = 8,
  parameter int LEN_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pipe_req,
  input  logic             pipe_we,
  input  logic [31:0]      pipe_addr,
  input  logic [31:0]      pipe_wdata,
  output logic [31:0]      pipe_rdata,
  output logic             pipe_stall,
  input  logic             ext_req,
  input  logic             ext_we,
  input  logic [31:0]      ext_addr,
  input  logic [LEN_W-1:0] ext_len,
  input  logic [31:0]      ext_wdata,
  output logic             ext_gnt,
  output logic             ext_ack,
  output logic [31:0]      ext_rdata,
  output logic             ext_done,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_we,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic [1:0] {S_PIPE, S_HAND, S_EXT} state_e;

  localparam int RUN_W = (MAX_PIPE_RUN > 1) ? $clog2(MAX_PIPE_RUN) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_PIPE_RUN - 1);

  state_e           state_q,    state_d;
  logic [RUN_W-1:0] run_cnt_q,  run_cnt_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0] len_q,      len_d;
  logic [31:0]      base_q,     base_d;
  logic             we_q,       we_d;
  logic             ext_gnt_q,  ext_gnt_d;
  logic             ext_done_q, ext_done_d;

  logic grant;
  logic last_beat;

  // Contention run limit forces the handover even if the pipeline never idles.
  assign grant     = ext_req & (~pipe_req | (run_cnt_q == RUN_LAST));
  assign last_beat = (beat_cnt_q == len_q);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_PIPE;
      run_cnt_q  <= '0;
      beat_cnt_q <= '0;
      len_q      <= '0;
      base_q     <= '0;
      we_q       <= 1'b0;
      ext_gnt_q  <= 1'b0;
      ext_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_cnt_q  <= run_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      base_q     <= base_d;
      we_q       <= we_d;
      ext_gnt_q  <= ext_gnt_d;
      ext_done_q <= ext_done_d;
    end
  end

  // NOTE: every combinational output gets a default before the case statement,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    base_d     = base_q;
    we_d       = we_q;
    ext_gnt_d  = ext_gnt_q;
    ext_done_d = 1'b0;
    unique case (state_q)
      S_PIPE: begin
        if (grant) begin
          state_d   = S_HAND;
          base_d    = ext_addr;
          len_d     = ext_len;
          we_d      = ext_we;
          ext_gnt_d = 1'b1;
          run_cnt_d = '0;
        end else if (!pipe_req) begin
          run_cnt_d = '0;
        end else if (ext_req) begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
      end
      S_HAND: begin
        state_d    = S_EXT;
        beat_cnt_d = '0;
      end
      S_EXT: begin
        if (!ext_req) begin
          state_d   = S_PIPE;
          ext_gnt_d = 1'b0;
        end else if (last_beat) begin
          state_d    = S_PIPE;
          ext_gnt_d  = 1'b0;
          ext_done_d = 1'b1;
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = S_PIPE;
    endcase
  end

  always_comb begin
    mem_addr   = pipe_addr;
    mem_wdata  = pipe_wdata;
    mem_we     = pipe_req & pipe_we;
    pipe_stall = 1'b0;
    ext_ack    = 1'b0;
    unique case (state_q)
      S_PIPE: ;
      S_HAND: begin
        mem_addr   = base_q;
        mem_wdata  = ext_wdata;
        mem_we     = 1'b0;
        pipe_stall = 1'b1;
      end
      S_EXT: begin
        // Address wraps modulo 2^32 at the top of memory.
        mem_addr   = base_q + 32'(beat_cnt_q);
        mem_wdata  = ext_wdata;
        mem_we     = we_q & ext_req;
        pipe_stall = 1'b1;
        ext_ack    = ext_req;
      end
      default: ;
    endcase
  end

  assign pipe_rdata = mem_rdata;
  assign ext_rdata  = mem_rdata;
  assign ext_gnt    = ext_gnt_q;
  assign ext_done   = ext_done_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic,
// compared cycle by cycle against a burst-level ownership model and a shadow memory.
module tb_dmem_arbiter;

  localparam int MAX   = 8;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             pipe_req, pipe_we;
  logic [31:0]      pipe_addr, pipe_wdata, pipe_rdata;
  logic             pipe_stall;
  logic             ext_req, ext_we;
  logic [31:0]      ext_addr, ext_wdata, ext_rdata;
  logic [LEN_W-1:0] ext_len;
  logic             ext_gnt, ext_ack, ext_done;
  logic [31:0]      mem_addr, mem_wdata, mem_rdata;
  logic             mem_we;

  dmem_arbiter #(.MAX_PIPE_RUN(MAX), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .pipe_req(pipe_req), .pipe_we(pipe_we), .pipe_addr(pipe_addr),
    .pipe_wdata(pipe_wdata), .pipe_rdata(pipe_rdata), .pipe_stall(pipe_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_len(ext_len),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_ack(ext_ack),
    .ext_rdata(ext_rdata), .ext_done(ext_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory seen by the DUT (256 words, aliased on the low address byte).
  logic [31:0] env_mem [256] = '{default: 32'h0};
  assign mem_rdata = env_mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) env_mem[mem_addr[7:0]] <= mem_wdata;

  // Reference: shadow memory plus ownership slot.
  // m_slot: -1 pipeline owns the port, 0 handover cycle, k>=1 external beat k-1.
  logic [31:0] model_mem [256] = '{default: 32'h0};
  int          m_slot, m_run, m_beats;
  logic [31:0] m_base;
  logic        m_we, m_gnt, m_done;

  logic        e_stall, e_ack, e_we, e_chk_wdata;
  logic [31:0] e_addr, e_wdata, e_rdata;

  int checks = 0;
  int errors = 0;

  int          n_stall, n_we, n_ack, n_done, n_pipe_pre;
  logic [31:0] last_ext_addr, last_pipe_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_slot = -1; m_run = 0; m_beats = 1; m_base = '0;
    m_we = 1'b0; m_gnt = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_outputs();
    e_stall = 1'b0; e_ack = 1'b0; e_chk_wdata = 1'b1;
    e_addr = pipe_addr; e_wdata = pipe_wdata;
    e_we = pipe_req & pipe_we;
    if (m_slot == 0) begin
      e_stall = 1'b1; e_we = 1'b0; e_addr = m_base; e_chk_wdata = 1'b0;
    end else if (m_slot >= 1) begin
      e_stall = 1'b1;
      e_ack   = ext_req;
      e_addr  = m_base + 32'(m_slot - 1);
      e_wdata = ext_wdata;
      e_we    = m_we & ext_req;
    end
    e_rdata = model_mem[e_addr[7:0]];
  endtask

  task automatic model_update();
    if (e_we) model_mem[e_addr[7:0]] = e_wdata;
    m_done = 1'b0;
    if (m_slot == -1) begin
      // Grant when the pipeline is idle or this is the MAX-th contended cycle in a row.
      if (ext_req && (!pipe_req || m_run + 1 == MAX)) begin
        m_slot = 0; m_base = ext_addr; m_beats = int'(ext_len) + 1;
        m_we = ext_we; m_gnt = 1'b1; m_run = 0;
      end else if (!pipe_req) m_run = 0;
      else if (ext_req) m_run++;
    end else if (m_slot == 0) begin
      m_slot = 1;
    end else if (!ext_req) begin
      m_slot = -1; m_gnt = 1'b0;
    end else if (m_slot == m_beats) begin
      m_slot = -1; m_gnt = 1'b0; m_done = 1'b1;
    end else begin
      m_slot++;
    end
  endtask

  // One clock: check mid-low-phase, advance the model at the edge, return at negedge.
  task automatic step();
    #1;
    model_outputs();
    check("pipe_stall", pipe_stall, e_stall);
    check("ext_ack",    ext_ack,    e_ack);
    check("mem_we",     mem_we,     e_we);
    check("mem_addr",   mem_addr,   e_addr);
    if (e_chk_wdata) check("mem_wdata", mem_wdata, e_wdata);
    check("pipe_rdata", pipe_rdata, e_rdata);
    check("ext_rdata",  ext_rdata,  e_rdata);
    check("ext_gnt",    ext_gnt,    m_gnt);
    check("ext_done",   ext_done,   m_done);
    if (pipe_stall === 1'b1) n_stall++;
    if (pipe_stall === 1'b1 && mem_we === 1'b1) n_we++;
    if (ext_ack === 1'b1) begin n_ack++; last_ext_addr = mem_addr; end
    if (ext_done === 1'b1) n_done++;
    if (pipe_req && pipe_stall === 1'b0 && n_stall == 0) n_pipe_pre++;
    last_pipe_rdata = pipe_rdata;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clear_counts();
    n_stall = 0; n_we = 0; n_ack = 0; n_done = 0; n_pipe_pre = 0;
    last_ext_addr = 'x;
  endtask

  // Runs one burst; abort_after >= 0 drops ext_req after that many beats.
  task automatic run_burst(input logic we, input logic [31:0] addr,
                           input logic [LEN_W-1:0] len, input logic preq,
                           input int abort_after);
    logic granted, finished;
    granted = 1'b0; finished = 1'b0;
    clear_counts();
    ext_req = 1'b1; ext_we = we; ext_addr = addr; ext_len = len;
    pipe_req = preq; pipe_we = 1'b0; pipe_addr = 32'h22;
    for (int c = 0; c < 100; c++) begin
      ext_wdata = (m_slot >= 1) ? 32'(m_slot) : $urandom;
      if (abort_after >= 0 && m_slot == abort_after + 1) ext_req = 1'b0;
      step();
      if (m_slot != -1) granted = 1'b1;
      else if (granted) begin
        ext_req = 1'b0;
        step();
        finished = 1'b1;
        break;
      end
    end
    check("burst_terminated", finished, 1'b1);
  endtask

  initial begin
    int pslot;
    model_reset();
    clear_counts();
    rst = 1'b0;
    pipe_req = 0; pipe_we = 0; pipe_addr = 0; pipe_wdata = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_len = 0; ext_wdata = 0;

    // Reset state, including combinational outputs following S_PIPE.
    #2;
    check("rst_gnt", ext_gnt, 1'b0);
    check("rst_done", ext_done, 1'b0);
    check("rst_stall", pipe_stall, 1'b0);
    check("rst_ack", ext_ack, 1'b0);
    pipe_req = 1; pipe_we = 1; pipe_addr = 32'h33; pipe_wdata = 32'h1234;
    #1;
    check("rst_mem_we", mem_we, 1'b1);
    check("rst_mem_addr", mem_addr, 32'h33);
    pipe_req = 0; pipe_we = 0;
    @(negedge clk);
    rst = 1'b1;

    // Pipeline write then read back.
    clear_counts();
    pipe_req = 1; pipe_we = 1; pipe_addr = 32'h10; pipe_wdata = 32'hDEADBEEF;
    step();
    pipe_we = 0;
    step();
    check("t1_readback", last_pipe_rdata, 32'hDEADBEEF);
    check("t1_no_stall", n_stall, 0);
    pipe_req = 0;
    step();

    // Idle pipeline, 4-beat write burst at 0x20.
    run_burst(1'b1, 32'h20, 4'd3, 1'b0, -1);
    check("t2_stall_cycles", n_stall, 5);
    check("t2_acks", n_ack, 4);
    check("t2_writes", n_we, 4);
    check("t2_last_addr", last_ext_addr, 32'h23);
    check("t2_done", n_done, 1);
    pipe_req = 1; pipe_we = 0; pipe_addr = 32'h22;
    step();
    check("t2_data", last_pipe_rdata, 32'd3);
    pipe_req = 0;
    step();

    // Continuous pipeline traffic: run limit forces a 1-beat burst in.
    run_burst(1'b0, 32'h40, 4'd0, 1'b1, -1);
    check("t3_pipe_before", n_pipe_pre, MAX);
    check("t3_stall_cycles", n_stall, 2);
    check("t3_acks", n_ack, 1);
    check("t3_done", n_done, 1);
    pipe_req = 0;
    step();

    // Burst across the top of the address space.
    run_burst(1'b1, 32'hFFFF_FFFE, 4'd2, 1'b0, -1);
    run_burst(1'b0, 32'hFFFF_FFFE, 4'd2, 1'b0, -1);
    check("t4_wrap_addr", last_ext_addr, 32'h0);
    check("t4_acks", n_ack, 3);

    // Abort after 2 of 4 beats.
    run_burst(1'b1, 32'h50, 4'd3, 1'b0, 2);
    check("t5_writes", n_we, 2);
    check("t5_done", n_done, 0);
    check("t5_stall_cycles", n_stall, 4);

    // Reset during beat 1 of a 6-beat burst.
    clear_counts();
    ext_req = 1; ext_we = 1; ext_addr = 32'h60; ext_len = 4'd5; pipe_req = 0;
    for (int c = 0; c < 10 && m_slot != 2; c++) begin
      ext_wdata = $urandom;
      step();
    end
    check("t6_in_beat1", ext_gnt, 1'b1);
    rst = 1'b0;
    #1;
    check("t6_stall", pipe_stall, 1'b0);
    check("t6_gnt", ext_gnt, 1'b0);
    check("t6_ack", ext_ack, 1'b0);
    check("t6_done", ext_done, 1'b0);
    model_reset();
    ext_req = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    clear_counts();
    pipe_req = 1; pipe_we = 0;
    for (int c = 0; c < 4; c++) begin
      pipe_addr = $urandom;
      step();
    end
    check("t6_no_done", n_done, 0);
    check("t6_no_stall", n_stall, 0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      pipe_req   = ($urandom % 4) != 0;
      pipe_we    = $urandom % 2;
      pipe_addr  = $urandom;
      pipe_wdata = $urandom;
      ext_wdata  = $urandom;
      if (m_slot == -1) begin
        if (!ext_req) ext_req = ($urandom % 8) == 0;
        ext_we   = $urandom % 2;
        ext_addr = $urandom;
        ext_len  = LEN_W'($urandom);
      end else if (m_slot >= 1 && ($urandom % 20) == 0) begin
        ext_req = 1'b0;
      end
      pslot = m_slot;
      step();
      if (pslot >= 1 && m_slot == -1) ext_req = $urandom % 2;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
